// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
package uart_tx_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCK
  } arb_state_t;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_t;

  localparam int FRAME_BITS       = 10;
  localparam int DEFAULT_BAUD_DIV = 868;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: accepts one byte per frame over valid/ready and shifts it
// out LSB first, with back-to-back acceptance in the final stop-bit cycle.
module uart_tx_serializer
  import uart_tx_arb_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_UART_Tx
);

  localparam int            BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  ser_state_t    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          bit_end;
  logic          accept;

  assign bit_end = (baud_q == BAUD_LAST);
  assign o_ready = (state_q == SER_IDLE) || ((state_q == SER_STOP) && bit_end);
  assign accept  = i_valid && o_ready;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    case (state_q)
      SER_IDLE: ;
      SER_START: begin
        if (bit_end) begin
          state_d = SER_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      SER_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == 3'd7) state_d = SER_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      SER_STOP: begin
        if (bit_end) begin
          state_d = SER_IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = SER_IDLE;
    endcase
    // A new byte overrides the stop-bit exit so frames abut with no gap.
    if (accept) begin
      state_d = SER_START;
      baud_d  = '0;
      shreg_d = i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= SER_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
    end
  end

  always_ff @(posedge i_clk) begin
    shreg_q <= shreg_d;
  end

  assign o_busy    = (state_q != SER_IDLE);
  assign o_UART_Tx = (state_q == SER_START) ? 1'b0 :
                     (state_q == SER_DATA)  ? shreg_q[0] : 1'b1;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one 8N1 UART line among N_REQ
// requesters. Define UART_TX_ARB_TIMEOUT_EN to revoke a lock after TIMEOUT idle cycles.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
  parameter int TIMEOUT  = 4096
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_busy,
  output logic               o_UART_Tx
);

  localparam int PW = $clog2(N_REQ);

  arb_state_t    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] sel, cur;
  logic          found;
  logic          ser_ready;
  logic          accept;
  logic          cur_last;
  logic [7:0]    cur_data;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] k);
    return (int'(k) == N_REQ - 1) ? '0 : k + 1'b1;
  endfunction

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    int c;
    c     = 0;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      c = int'(ptr_q) + i;
      if (c >= N_REQ) c = c - N_REQ;
      if (!found && i_req_valid[c]) begin
        found = 1'b1;
        sel   = PW'(c);
      end
    end
  end

  assign cur = (state_q == ARB_LOCK) ? owner_q : sel;

  always_comb begin
    o_req_ready = '0;
    if (ser_ready && ((state_q == ARB_LOCK) || found)) o_req_ready[cur] = 1'b1;
  end

  always_comb begin
    o_grant = '0;
    if (state_q == ARB_LOCK) o_grant[owner_q] = 1'b1;
  end

  assign accept   = |(i_req_valid & o_req_ready);
  assign cur_data = i_req_data[8*cur +: 8];
  assign cur_last = i_req_last[cur];

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] to_q, to_d;
  logic          to_hit;

  assign to_hit = (state_q == ARB_LOCK) && !accept && !i_req_valid[owner_q] && (to_q == TO_LAST);

  always_comb begin
    to_d = to_q;
    if ((state_q != ARB_LOCK) || accept) to_d = '0;
    else if (!i_req_valid[owner_q])      to_d = to_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) to_q <= '0;
    else       to_q <= to_d;
  end
`else
  logic to_hit;
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (accept) begin
      if (cur_last) begin
        state_d = ARB_IDLE;
        ptr_d   = wrap_inc(cur);
      end else begin
        state_d = ARB_LOCK;
        owner_d = cur;
      end
    end else if (to_hit) begin
      // Abandon the partial message; the frame in flight still completes.
      state_d = ARB_IDLE;
      ptr_d   = wrap_inc(owner_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  uart_tx_serializer #(
    .BAUD_DIV (BAUD_DIV)
  ) u_ser (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (accept),
    .i_data    (cur_data),
    .o_ready   (ser_ready),
    .o_busy    (o_busy),
    .o_UART_Tx (o_UART_Tx)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with two requesters and BAUD_DIV=4.
// The timeout scenario is built only when UART_TX_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

  localparam int N  = 2;
  localparam int BD = 4;
  localparam int TO = 8;

  logic        s_clk = 1'b0;
  logic        rst;
  logic [1:0]  valid, last, ready, grant;
  logic [15:0] data;
  logic        busy, tx;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [8:0] rq0[$];
  logic [8:0] rq1[$];
  logic [7:0] exp_q[$];
  int         starts[$];

  logic [1:0] acc;
  int         acc_cyc;
  int         n_acc;
  logic       mdl_lock;
  int         mdl_owner;
  logic       mon_en = 1'b1;

  always #5 s_clk = ~s_clk;
  always @(posedge s_clk) cyc <= cyc + 1;

  uart_tx_arbiter #(
    .N_REQ    (N),
    .BAUD_DIV (BD),
    .TIMEOUT  (TO)
  ) dut (
    .i_clk       (s_clk),
    .i_rst       (rst),
    .i_req_valid (valid),
    .i_req_data  (data),
    .i_req_last  (last),
    .o_req_ready (ready),
    .o_grant     (grant),
    .o_busy      (busy),
    .o_UART_Tx   (tx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic drain(input string tag, input int budget);
    int i;
    i = 0;
    while ((exp_q.size() > 0 || rq0.size() > 0 || rq1.size() > 0 || busy) && i < budget) begin
      @(negedge s_clk);
      i++;
    end
    chk({tag, "_drain"}, 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    @(negedge s_clk);
    rst      = 1'b1;
    mdl_lock = 1'b0;
    @(negedge s_clk);
    rst = 1'b0;
  endtask

  // Requester driver: presents queue heads, retires bytes on handshake.
  initial begin
    valid = '0; last = '0; data = '0; acc = '0;
    n_acc = 0; acc_cyc = 0; mdl_lock = 1'b0; mdl_owner = 0;
    forever begin
      @(negedge s_clk);
      if (acc[0]) void'(rq0.pop_front());
      if (acc[1]) void'(rq1.pop_front());
      valid[0] = (rq0.size() > 0);
      valid[1] = (rq1.size() > 0);
      if (valid[0]) {last[0], data[7:0]}  = rq0[0];
      if (valid[1]) {last[1], data[15:8]} = rq1[0];
      #1;
      acc = rst ? 2'b00 : (valid & ready);
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) begin
          chk("grant_at_accept", 32'(grant), (mdl_lock && mdl_owner == k) ? (32'd1 << k) : 32'd0);
          mdl_lock  = !last[k];
          mdl_owner = k;
          acc_cyc   = cyc + 1;
          n_acc++;
        end
      end
    end
  end

  // Line monitor: decodes each frame at mid-bit and pops the scoreboard.
  initial begin
    logic [7:0] b;
    b = '0;
    forever begin
      @(negedge s_clk);
      if (mon_en && tx === 1'b0) begin
        starts.push_back(cyc);
        chk("busy_in_frame", 32'(busy), 1);
        repeat (2) @(negedge s_clk);
        chk("start_bit", 32'(tx), 0);
        for (int j = 0; j < 8; j++) begin
          repeat (4) @(negedge s_clk);
          b[j] = tx;
        end
        repeat (4) @(negedge s_clk);
        chk("stop_bit", 32'(tx), 1);
        chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("rx_byte", 32'(b), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int n0, a, w;
    rst = 1'b1;
    repeat (3) @(negedge s_clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ready", 32'(ready), 0);
    rst = 1'b0;

    // Single byte from requester 0
    starts.delete();
    exp_q.push_back(8'h48);
    rq0.push_back({1'b1, 8'h48});
    drain("single", 200);
    chk("single_frames", 32'(starts.size()), 1);
    if (starts.size() > 0) chk("single_latency", 32'(starts[0]), 32'(acc_cyc));

    // Message lock: pointer is now 1, so requester 1 wins and holds the line
    exp_q.push_back(8'h61); exp_q.push_back(8'h62);
    exp_q.push_back(8'h63); exp_q.push_back(8'h5A);
    rq1.push_back({1'b0, 8'h61}); rq1.push_back({1'b0, 8'h62}); rq1.push_back({1'b1, 8'h63});
    rq0.push_back({1'b1, 8'h5A});
    drain("lock", 400);

    // Simultaneous single bytes after reset
    do_reset();
    starts.delete();
    exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    rq0.push_back({1'b1, 8'h41});
    rq1.push_back({1'b1, 8'h42});
    drain("simul", 300);
    chk("simul_frames", 32'(starts.size()), 2);
    if (starts.size() == 2) chk("b2b_gap", 32'(starts[1] - starts[0]), 40);

    // Fairness: five single-byte messages each, continuously
    starts.delete();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      exp_q.push_back(8'h20 + 8'(i));
      rq0.push_back({1'b1, 8'h10 + 8'(i)});
      rq1.push_back({1'b1, 8'h20 + 8'(i)});
    end
    drain("fair", 700);
    chk("fair_frames", 32'(starts.size()), 10);
    if (starts.size() == 10)
      for (int i = 1; i < 10; i++) chk("fair_gap", 32'(starts[i] - starts[i-1]), 40);

    // Reset 15 cycles into a frame
    mon_en = 1'b0;
    n0 = n_acc;
    rq0.push_back({1'b1, 8'h99});
    w = 0;
    while (n_acc == n0 && w < 50) begin @(negedge s_clk); w++; end
    chk("midrst_accept", 32'(n_acc - n0), 1);
    repeat (15) @(negedge s_clk);
    chk("midrst_busy_before", 32'(busy), 1);
    rst = 1'b1;
    mdl_lock = 1'b0;
    @(negedge s_clk);
    chk("midrst_tx", 32'(tx), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_grant", 32'(grant), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    exp_q.push_back(8'h3C);
    rq0.push_back({1'b1, 8'h3C});
    drain("after_rst", 200);

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Lock abandoned after TIMEOUT idle cycles
    do_reset();
    n0 = n_acc;
    exp_q.push_back(8'h01); exp_q.push_back(8'h77);
    rq0.push_back({1'b0, 8'h01});
    rq1.push_back({1'b1, 8'h77});
    w = 0;
    while (n_acc == n0 && w < 50) begin @(negedge s_clk); w++; end
    chk("to_first_accept", 32'(n_acc - n0), 1);
    a = acc_cyc;
    w = 0;
    while (cyc < a + 7 && w < 50) begin @(negedge s_clk); w++; end
    chk("to_grant_held", 32'(grant), 32'b01);
    @(negedge s_clk);
    chk("to_grant_revoked", 32'(grant), 0);
    drain("timeout", 300);
`else
    a = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares a single UART transmit line between N_REQ independent byte-stream requesters, such as processor cores or message generators. Whole messages are granted round-robin: once a requester sends its first byte, it keeps the line until it presents a byte flagged last. Granted bytes are serialized as 8N1 frames on `o_UART_Tx` at a rate set by a fixed clock divider. The block sits between the message sources and the board UART pin, replacing a direct single-source transmitter.

## Interface
- `N_REQ`, default 2: number of requesters, 2..8.
- `BAUD_DIV`, default 868: clock cycles per bit (100 MHz / 115200, rounded).
- `TIMEOUT`, default 4096: idle cycles before a locked grant is revoked. Used only with `UART_TX_ARB_TIMEOUT_EN`.

Ports:
- `i_clk`  in  1: single clock.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_req_valid`  in  N_REQ: requester k has a byte.
- `i_req_data`  in  8*N_REQ: byte k is in bits [8k+:8].
- `i_req_last`  in  N_REQ: byte k ends its message.
- `o_req_ready`  out  N_REQ: one-hot; byte k is accepted when valid[k] & ready[k].
- `o_grant`  out  N_REQ: one-hot current owner; zero when no requester is locked.
- `o_busy`  out  1: a frame is being shifted out.
- `o_UART_Tx`  out  1: serial output; idles high.

## Operation
- **Reset values:** `o_UART_Tx`=1, `o_req_ready`=0, `o_grant`=0, `o_busy`=0, round-robin pointer=0, arbiter in ARB_IDLE, serializer in SER_IDLE.
- **Arbiter states:**
  - ARB_IDLE: select the first k with valid[k] set, searching from the pointer upward and wrapping. `o_grant` is 0 in this state. When a byte is accepted with last=1, stay in ARB_IDLE and set pointer = k+1 mod N_REQ. When a byte is accepted with last=0, go to ARB_LOCK(k).
  - ARB_LOCK(k): `o_grant`=onehot(k); only requester k can be made ready. Accepting a byte with last=1 returns to ARB_IDLE and sets pointer = k+1.
  - In both states, `o_req_ready[k]` is asserted only when the serializer can take a byte.
- **Serializer states:** SER_IDLE → SER_START (line 0) → SER_DATA (8 bits, LSB first) → SER_STOP (line 1) → SER_IDLE.
  - Each state lasts BAUD_DIV cycles per bit.
  - The bit counter is 3 bits; the baud counter is clog2(BAUD_DIV) bits.
- **Serializer can accept** when it is in SER_IDLE, or in the last cycle of SER_STOP. This allows back-to-back frames.
- An accepted byte is latched into the shift register in the same cycle it is accepted.
- A requester dropping valid while locked holds the lock. `o_UART_Tx` stays high between frames.
- If valid bits change while in ARB_IDLE, the selection is re-evaluated every cycle. Only an accepted byte commits the choice.

## Timing
- The handshake is combinational from `i_req_valid` to `o_req_ready`; there are no other combinational paths.
- `o_UART_Tx` falls (start bit) in the cycle after acceptance.
- One frame takes exactly 10*BAUD_DIV cycles. Back-to-back frames have no idle gap.
- `o_busy` is 1 from the cycle after acceptance until the end of the stop bit.
- **Simultaneous events:**
  - Accepting a last=1 byte from k and a new request arriving in the same cycle: the new grant is evaluated in the next cycle from the updated pointer.
  - `i_rst` asserted mid-frame: at the next edge all outputs take their reset values and the frame is truncated; the line returns high.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined: in ARB_LOCK(k), a counter increments on each cycle with valid[k]=0 and clears on each accepted byte.
  - When the counter reaches TIMEOUT, the arbiter returns to ARB_IDLE with pointer = k+1.
  - A partial message is abandoned; any frame in flight completes.
- `UART_TX_ARB_TIMEOUT_EN` undefined: there is no counter, and the lock is held indefinitely until a last=1 byte is accepted.

## Structure
- Package `uart_tx_arb_pkg` holds:
  - the arbiter state enum and the serializer state enum;
  - `FRAME_BITS`=10;
  - the default BAUD_DIV constant.
- Sub-module `uart_tx_serializer`: baud counter, shift register and the 8N1 state machine. Its interface is a valid/ready byte input plus `o_UART_Tx` and `o_busy`.
- The top-level block contains the arbiter, the round-robin pointer, and the optional timeout counter.

## Test plan
All scenarios use BAUD_DIV=4, so one frame is 40 cycles.
- **Single byte:** requester 0 sends 0x48, last=1, after reset.
  - Line goes low 1 cycle after acceptance, then bits 0,0,0,1,0,0,1,0, then high; frame lasts 40 cycles.
  - `o_grant` stays 0 and the pointer becomes 1.
- **Simultaneous single bytes:** requesters 0 and 1 both present single-byte messages 0x41 and 0x42.
  - 0x41 is sent first, 0x42 follows back-to-back; the second start bit is exactly 40 cycles after the first.
- **Message lock:** requester 1 sends "abc" (last on 'c') while requester 0 holds 0x5A valid.
  - Output order is 0x61, 0x62, 0x63, 0x5A; `o_grant`=2'b10 from the 'a' acceptance until the 'c' acceptance.
- **Fairness:** requesters 0 and 1 each send five single-byte messages continuously.
  - Output alternates 0,1,0,1,...
- **Reset mid-frame:** pulse `i_rst` 15 cycles into a frame.
  - In the next cycle `o_UART_Tx`=1 and busy=0; the next byte sent afterwards produces a clean frame.
- **Timeout (with `UART_TX_ARB_TIMEOUT_EN`, TIMEOUT=8):** requester 0 sends one byte with last=0, then drops valid.
  - After 8 idle cycles the grant returns to 0, and requester 1's pending byte is accepted.
